// File: rtl/demux2_pkg.sv
// Shared defaults and types for the two-way stream demultiplexer.
// Optional per-channel delivery counters are enabled with DEMUX2_STATS_EN.
package demux2_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned DEFAULT_DEPTH = 2;

  typedef logic [DEFAULT_WIDTH-1:0] data_t;
  typedef logic [7:0]               cnt_t;

  // Occupancy counter width able to hold 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a DEPTH+1-state occupancy count; head word reads as 0 when empty.
// Reset is synchronous, active-low.
module sync_fifo
  import demux2_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             wr_en, rd_en;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign wr_en   = push_i & ~full_o;
  assign rd_en   = pop_i & ~empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to 0 while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/demux2_stream.sv
// Routes a valid/ready stream to one of two independently buffered outputs.
// Define DEMUX2_STATS_EN to add per-channel 8-bit delivered-word counters cnt0_o/cnt1_o.
module demux2_stream
  import demux2_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_sel_i,
  output logic             out0_valid_o,
  input  logic             out0_ready_i,
  output logic [WIDTH-1:0] out0_data_o,
  output logic             out1_valid_o,
  input  logic             out1_ready_i,
`ifdef DEMUX2_STATS_EN
  output cnt_t             cnt0_o,
  output cnt_t             cnt1_o,
`endif
  output logic [WIDTH-1:0] out1_data_o
);

  logic full0, full1, empty0, empty1;
  logic push0, push1, pop0, pop1;
  logic accept;

  // Ready depends only on the selected buffer, never on a same-cycle pop.
  assign in_ready_o = rst & ~(in_sel_i ? full1 : full0);
  assign accept     = in_valid_i & in_ready_o;
  assign push0      = accept & ~in_sel_i;
  assign push1      = accept & in_sel_i;

  assign out0_valid_o = ~empty0;
  assign out1_valid_o = ~empty1;
  assign pop0         = out0_valid_o & out0_ready_i;
  assign pop1         = out1_valid_o & out1_ready_i;

  sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo0 (
    .clk    (clk),
    .rst    (rst),
    .push_i (push0),
    .pop_i  (pop0),
    .data_i (in_data_i),
    .data_o (out0_data_o),
    .full_o (full0),
    .empty_o(empty0)
  );

  sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo1 (
    .clk    (clk),
    .rst    (rst),
    .push_i (push1),
    .pop_i  (pop1),
    .data_i (in_data_i),
    .data_o (out1_data_o),
    .full_o (full1),
    .empty_o(empty1)
  );

`ifdef DEMUX2_STATS_EN
  cnt_t cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (pop0) cnt0_d = cnt0_q + cnt_t'(1);
    if (pop1) cnt1_d = cnt1_q + cnt_t'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0_o = cnt0_q;
  assign cnt1_o = cnt1_q;
`endif

endmodule

// File: tb/tb_demux2_stream.sv
// Directed, table-driven bench for demux2_stream plus a long FIFO-order sequence.
// Counter checks are compiled in when DEMUX2_STATS_EN is defined.
module tb_demux2_stream;

  logic       clk;
  logic       rst;
  logic       in_valid, in_ready, in_sel;
  logic [3:0] in_data;
  logic       out0_valid, out0_ready, out1_valid, out1_ready;
  logic [3:0] out0_data, out1_data;
`ifdef DEMUX2_STATS_EN
  logic [7:0] cnt0, cnt1;
`endif

  int n_cmp;
  int n_bad;

  demux2_stream #(
    .WIDTH(4),
    .DEPTH(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_sel_i    (in_sel),
    .out0_valid_o(out0_valid),
    .out0_ready_i(out0_ready),
    .out0_data_o (out0_data),
    .out1_valid_o(out1_valid),
    .out1_ready_i(out1_ready),
`ifdef DEMUX2_STATS_EN
    .cnt0_o      (cnt0),
    .cnt1_o      (cnt1),
`endif
    .out1_data_o (out1_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs for one cycle and the outputs expected before that cycle's edge.
  typedef struct packed {
    logic       rst;
    logic       iv;
    logic       sel;
    logic [3:0] d;
    logic       r0;
    logic       r1;
    logic       ir;
    logic       v0;
    logic [3:0] d0;
    logic       v1;
    logic [3:0] d1;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int         sent;
    int         recvd;
    logic [3:0] model_q[$];
    logic [3:0] exp_w;
    n_cmp = 0;
    n_bad = 0;

    //           rst  iv   sel  d     r0   r1   ir   v0   d0    v1   d1
    vq.push_back({1'b0,1'b1,1'b0,4'h3,1'b1,1'b1,1'b0,1'b0,4'h0,1'b0,4'h0});
    vq.push_back({1'b0,1'b1,1'b1,4'h5,1'b1,1'b1,1'b0,1'b0,4'h0,1'b0,4'h0});
    vq.push_back({1'b1,1'b1,1'b0,4'hA,1'b1,1'b1,1'b1,1'b0,4'h0,1'b0,4'h0});
    vq.push_back({1'b1,1'b1,1'b1,4'h5,1'b1,1'b1,1'b1,1'b1,4'hA,1'b0,4'h0});
    vq.push_back({1'b1,1'b0,1'b0,4'h0,1'b1,1'b1,1'b1,1'b0,4'h0,1'b1,4'h5});
    vq.push_back({1'b1,1'b0,1'b1,4'hF,1'b1,1'b1,1'b1,1'b0,4'h0,1'b0,4'h0});
    vq.push_back({1'b1,1'b0,1'b0,4'h0,1'b1,1'b1,1'b1,1'b0,4'h0,1'b0,4'h0});
    // Channel 0 stalled: two words fit, the third is refused.
    vq.push_back({1'b1,1'b1,1'b0,4'h1,1'b0,1'b1,1'b1,1'b0,4'h0,1'b0,4'h0});
    vq.push_back({1'b1,1'b1,1'b0,4'h2,1'b0,1'b1,1'b1,1'b1,4'h1,1'b0,4'h0});
    vq.push_back({1'b1,1'b1,1'b0,4'h3,1'b0,1'b1,1'b0,1'b1,4'h1,1'b0,4'h0});
    vq.push_back({1'b1,1'b1,1'b1,4'hF,1'b0,1'b1,1'b1,1'b1,4'h1,1'b0,4'h0});
    vq.push_back({1'b1,1'b1,1'b0,4'h3,1'b0,1'b1,1'b0,1'b1,4'h1,1'b1,4'hF});
    // Full buffer refuses even while being popped.
    vq.push_back({1'b1,1'b1,1'b0,4'h3,1'b1,1'b1,1'b0,1'b1,4'h1,1'b0,4'h0});
    vq.push_back({1'b1,1'b1,1'b0,4'h3,1'b1,1'b1,1'b1,1'b1,4'h2,1'b0,4'h0});
    vq.push_back({1'b1,1'b0,1'b0,4'h0,1'b1,1'b1,1'b1,1'b1,4'h3,1'b0,4'h0});
    vq.push_back({1'b1,1'b0,1'b0,4'h0,1'b1,1'b1,1'b1,1'b0,4'h0,1'b0,4'h0});
    // Fill both channels, then reset mid-operation.
    vq.push_back({1'b1,1'b1,1'b0,4'h6,1'b0,1'b0,1'b1,1'b0,4'h0,1'b0,4'h0});
    vq.push_back({1'b1,1'b1,1'b0,4'h7,1'b0,1'b0,1'b1,1'b1,4'h6,1'b0,4'h0});
    vq.push_back({1'b1,1'b1,1'b1,4'h8,1'b0,1'b0,1'b1,1'b1,4'h6,1'b0,4'h0});
    vq.push_back({1'b1,1'b1,1'b1,4'h9,1'b0,1'b0,1'b1,1'b1,4'h6,1'b1,4'h8});
    vq.push_back({1'b0,1'b1,1'b0,4'hC,1'b1,1'b1,1'b0,1'b1,4'h6,1'b1,4'h8});
    vq.push_back({1'b1,1'b0,1'b0,4'h0,1'b1,1'b1,1'b1,1'b0,4'h0,1'b0,4'h0});
    vq.push_back({1'b1,1'b1,1'b1,4'hB,1'b1,1'b1,1'b1,1'b0,4'h0,1'b0,4'h0});
    vq.push_back({1'b1,1'b0,1'b0,4'h0,1'b1,1'b1,1'b1,1'b0,4'h0,1'b1,4'hB});
    vq.push_back({1'b1,1'b0,1'b0,4'h0,1'b1,1'b1,1'b1,1'b0,4'h0,1'b0,4'h0});

    rst        = 1'b0;
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    in_data    = 4'h0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    next_cycle();

    foreach (vq[i]) begin
      rst        = vq[i].rst;
      in_valid   = vq[i].iv;
      in_sel     = vq[i].sel;
      in_data    = vq[i].d;
      out0_ready = vq[i].r0;
      out1_ready = vq[i].r1;
      #1;
      chk("in_ready",   i, 32'(in_ready),   32'(vq[i].ir));
      chk("out0_valid", i, 32'(out0_valid), 32'(vq[i].v0));
      chk("out0_data",  i, 32'(out0_data),  32'(vq[i].d0));
      chk("out1_valid", i, 32'(out1_valid), 32'(vq[i].v1));
      chk("out1_data",  i, 32'(out1_data),  32'(vq[i].d1));
      next_cycle();
    end

    // 257 transfers on channel 1 with order checked against a queue model.
    rst      = 1'b0;
    in_valid = 1'b0;
    next_cycle();
    rst   = 1'b1;
    sent  = 0;
    recvd = 0;
    for (int cyc = 0; cyc < 600 && recvd < 257; cyc++) begin
      in_valid   = (sent < 257);
      in_sel     = 1'b1;
      in_data    = 4'(sent * 7 + 3);
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      #1;
      if (out1_valid) begin
        exp_w = (model_q.size() > 0) ? model_q.pop_front() : 4'hx;
        chk("ch1_order", recvd, 32'(out1_data), 32'(exp_w));
        recvd++;
      end
      if (in_valid && in_ready) begin
        model_q.push_back(in_data);
        sent++;
      end
      next_cycle();
    end
    in_valid = 1'b0;
    chk("ch1_transfers", 0, 32'(recvd), 32'd257);
    chk("ch0_idle", 0, 32'(out0_valid), 32'd0);
`ifdef DEMUX2_STATS_EN
    chk("cnt1_wrap", 0, 32'(cnt1), 32'd1);
    chk("cnt0_zero", 0, 32'(cnt0), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/demux2_stream.md
DEMUX2_STREAM -- requirements
Module: demux2_stream

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the data word width in bits.
REQ-002 Parameter DEPTH, default 2, SHALL set the per-output buffer depth in entries; legal values are powers of two ≥ 2.
REQ-003 clk  input  1  SHALL be the clock; all state updates on the rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 in_valid  input  1  SHALL mean the source is offering a word.
REQ-006 in_ready  output  1  SHALL mean the block accepts the offered word this cycle.
REQ-007 in_data  input  WIDTH  SHALL carry the offered word.
REQ-008 in_sel  input  1  SHALL route the word: 0 to output 0, 1 to output 1.
REQ-009 out0_valid / out1_valid  output  1 each  SHALL mean the channel head word is presented.
REQ-010 out0_ready / out1_ready  input  1 each  SHALL mean the sink takes the presented word.
REQ-011 out0_data / out1_data  output  WIDTH each  SHALL carry the channel head word.
REQ-012 cnt0 / cnt1  output  8 each  SHALL report words delivered per channel (present only with DEMUX2_STATS_EN).

Function
REQ-013 Input transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; output transfer SHALL occur where outN_valid=1 and outN_ready=1.
REQ-014 in_ready SHALL equal NOT full of the buffer selected by in_sel, combinationally; a full buffer SHALL NOT accept a word even if it is popped in the same cycle.
REQ-015 Each accepted word SHALL be written only to the buffer selected by in_sel; the other buffer is unaffected.
REQ-016 Latency SHALL be one cycle: a word accepted at edge k into an empty buffer is presented with outN_valid=1 after edge k.
REQ-017 outN_valid SHALL equal NOT empty of buffer N; outN_data SHALL be the oldest unread word of buffer N, and 0 when empty.
REQ-018 Per-channel order SHALL be preserved (FIFO); channels SHALL be independent, so a stalled channel never blocks the other channel.
REQ-019 While outN_valid=1 and outN_ready=0, outN_data SHALL remain stable.
REQ-020 Simultaneous push and pop on a non-full, non-empty buffer SHALL leave its occupancy unchanged; on an empty buffer the pushed word SHALL appear the next cycle.
REQ-021 Read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL be tracked with a DEPTH+1-state count so full and empty are unambiguous.
REQ-022 in_valid=0 SHALL cause no state change on the input side, regardless of in_sel and in_data.

Reset
REQ-023 With rst=0 at a rising edge, both buffers SHALL become empty, all valids 0, all data outputs 0, counters 0.
REQ-024 Reset mid-operation SHALL discard buffered words; no word accepted before reset is presented after it.
REQ-025 in_ready SHALL be 0 during any cycle with rst=0.

Configuration
REQ-026 With macro DEMUX2_STATS_EN defined, cnt0/cnt1 SHALL exist and increment by 1 per output transfer on their channel, wrapping 255→0.
REQ-027 Without DEMUX2_STATS_EN, cnt0/cnt1 and their registers SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 Package demux2_pkg SHALL hold WIDTH/DEPTH defaults, typedef data_t (logic [WIDTH-1:0]) and typedef cnt_t (logic [7:0]).
REQ-029 Sub-module sync_fifo (push/pop, full/empty, head data) SHALL be instantiated twice, once per channel; routing and in_ready logic live in demux2_stream.

Verification
REQ-030 Reset: rst=0 for 3 cycles with in_valid=1 -> in_ready=0, out0_valid=out1_valid=0, out0_data=out1_data=4'b0000.
REQ-031 Routing: send 4'b1010 sel=0, then 4'b0101 sel=1, both sinks ready -> out0_data=1010 and out1_data=0101, each one cycle after acceptance.
REQ-032 Backpressure: out0_ready=0, send 4'b0001, 4'b0010, 4'b0011 on sel=0 -> first two accepted, in_ready=0 on the third; out0_data holds 0001; after out0_ready=1, words emerge as 0001, 0010, 0011.
REQ-033 Independence: channel 0 full and stalled, send 4'b1111 sel=1 -> accepted immediately, out1_data=1111 next cycle.
REQ-034 Reset mid-operation: both buffers hold 2 words, pulse rst=0 one cycle -> both valids 0 afterwards, no old word ever reappears.
REQ-035 Stats (DEMUX2_STATS_EN): 257 transfers on channel 1 -> cnt1=1 and cnt0=0.
